// File: rtl/snake_body_if.sv
// Move request / segment stream bundle between the game controller and snake_body.
interface snake_body_if;
  logic       tick;
  logic [1:0] dir;
  logic       is_eat;
  logic [4:0] x_snake_cur;
  logic [4:0] y_snake_cur;
  logic [9:0] length;
  logic       vld;
  logic       vld_start;
  logic       vld_t;
  logic       pixel_done;
  logic       is_end;
  logic       dead;

  modport master (
    output tick, dir, is_eat,
    input  x_snake_cur, y_snake_cur, length, vld, vld_start, vld_t,
           pixel_done, is_end, dead
  );

  modport slave (
    input  tick, dir, is_eat,
    output x_snake_cur, y_snake_cur, length, vld, vld_start, vld_t,
           pixel_done, is_end, dead
  );
endinterface

// File: rtl/snake_body.sv
// Snake segment store: moves/grows on tick, streams segments head-first, detects death.
// Define SNAKE_WRAP_EN to wrap at the grid edges instead of dying there.
module snake_body #(
  parameter logic [4:0] H_LOGIC_MAX = 5'd31,
  parameter logic [4:0] V_LOGIC_MAX = 5'd23,
  parameter int         MAX_LEN     = 201
) (
  input logic         clk,
  input logic         rst,
  snake_body_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MOVE, STREAM, DEAD} state_t;

  localparam logic [1:0] RIGHT   = 2'd0;
  localparam logic [1:0] LEFT    = 2'd1;
  localparam logic [1:0] UP      = 2'd2;
  localparam logic [1:0] DOWN    = 2'd3;
  localparam int         AW      = $clog2(MAX_LEN);
  localparam logic [9:0] LEN_MAX = 10'(MAX_LEN);

  state_t          state_reg;
  logic [1:0]      heading_reg;
  logic [9:0]      length_reg;
  logic [AW-1:0]   idx_reg;
  logic            grow_reg;
  logic            collision_reg;
  logic            dead_reg;
  logic            vld_reg;
  logic            vld_start_reg;
  logic            vld_t_reg;
  logic            pixel_done_reg;
  logic            is_end_reg;
  logic [4:0]      x_cur_reg;
  logic [4:0]      y_cur_reg;
  logic [4:0]      seg_x [MAX_LEN];
  logic [4:0]      seg_y [MAX_LEN];

  logic [1:0]      heading_next;
  logic [4:0]      head_x_next;
  logic [4:0]      head_y_next;
  logic [9:0]      length_next;
  logic [AW-1:0]   idx_plus;
  logic            off_grid;
  logic            step_dead;
  logic            shift_en;
  logic            hit;

  always_comb begin
    // Opposite headings (R/L, U/D) differ only in bit 0.
    heading_next = ((bus.dir ^ heading_reg) == 2'b01) ? heading_reg : bus.dir;
    head_x_next  = seg_x[0];
    head_y_next  = seg_y[0];
    off_grid     = 1'b0;
    case (heading_next)
      RIGHT: begin
        off_grid    = (seg_x[0] == H_LOGIC_MAX);
        head_x_next = off_grid ? 5'd0 : seg_x[0] + 5'd1;
      end
      LEFT: begin
        off_grid    = (seg_x[0] == 5'd0);
        head_x_next = off_grid ? H_LOGIC_MAX : seg_x[0] - 5'd1;
      end
      UP: begin
        off_grid    = (seg_y[0] == 5'd0);
        head_y_next = off_grid ? V_LOGIC_MAX : seg_y[0] - 5'd1;
      end
      default: begin
        off_grid    = (seg_y[0] == V_LOGIC_MAX);
        head_y_next = off_grid ? 5'd0 : seg_y[0] + 5'd1;
      end
    endcase
  end

`ifdef SNAKE_WRAP_EN
  assign step_dead = 1'b0;
`else
  assign step_dead = off_grid;
`endif

  assign shift_en    = (state_reg == MOVE) && !step_dead;
  assign length_next = (grow_reg && length_reg < LEN_MAX) ? length_reg + 10'd1 : length_reg;
  assign idx_plus    = idx_reg + AW'(1);
  // The body segment on the outputs this cycle is compared against the head.
  assign hit         = vld_t_reg && (x_cur_reg == seg_x[0]) && (y_cur_reg == seg_y[0]);

  // Shifting every slot also parks the old tail at index length, which is what growth needs.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_x[0] <= '0;
      seg_y[0] <= '0;
    end else if (shift_en) begin
      seg_x[0] <= head_x_next;
      seg_y[0] <= head_y_next;
      for (int k = 1; k < MAX_LEN; k++) begin
        seg_x[k] <= seg_x[k-1];
        seg_y[k] <= seg_y[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      heading_reg    <= RIGHT;
      length_reg     <= 10'd1;
      idx_reg        <= '0;
      grow_reg       <= 1'b0;
      collision_reg  <= 1'b0;
      dead_reg       <= 1'b0;
      vld_reg        <= 1'b0;
      vld_start_reg  <= 1'b0;
      vld_t_reg      <= 1'b0;
      pixel_done_reg <= 1'b0;
      is_end_reg     <= 1'b0;
      x_cur_reg      <= '0;
      y_cur_reg      <= '0;
    end else begin
      vld_reg        <= 1'b0;
      vld_start_reg  <= 1'b0;
      vld_t_reg      <= 1'b0;
      pixel_done_reg <= 1'b0;
      is_end_reg     <= 1'b0;
      if (bus.is_eat && state_reg != DEAD)
        grow_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (bus.tick) begin
            state_reg <= MOVE;
            vld_reg   <= 1'b1;
          end
        end
        MOVE: begin
          heading_reg <= heading_next;
          // An eat arriving now belongs to the next move.
          grow_reg    <= bus.is_eat;
          if (step_dead) begin
            state_reg <= DEAD;
            dead_reg  <= 1'b1;
          end else begin
            state_reg      <= STREAM;
            length_reg     <= length_next;
            idx_reg        <= '0;
            x_cur_reg      <= head_x_next;
            y_cur_reg      <= head_y_next;
            pixel_done_reg <= 1'b1;
            vld_start_reg  <= 1'b1;
            is_end_reg     <= (length_next == 10'd1);
          end
        end
        STREAM: begin
          if (hit)
            collision_reg <= 1'b1;
          if (is_end_reg) begin
            collision_reg <= 1'b0;
            x_cur_reg     <= seg_x[0];
            y_cur_reg     <= seg_y[0];
            if (collision_reg || hit) begin
              state_reg <= DEAD;
              dead_reg  <= 1'b1;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            idx_reg        <= idx_plus;
            x_cur_reg      <= seg_x[idx_plus];
            y_cur_reg      <= seg_y[idx_plus];
            pixel_done_reg <= 1'b1;
            vld_t_reg      <= 1'b1;
            is_end_reg     <= (10'(idx_reg) + 10'd2 == length_reg);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.x_snake_cur = x_cur_reg;
  assign bus.y_snake_cur = y_cur_reg;
  assign bus.length      = length_reg;
  assign bus.vld         = vld_reg;
  assign bus.vld_start   = vld_start_reg;
  assign bus.vld_t       = vld_t_reg;
  assign bus.pixel_done  = pixel_done_reg;
  assign bus.is_end      = is_end_reg;
  assign bus.dead        = dead_reg;
endmodule

// File: tb/tb_snake_body.sv
// Bench for snake_body: directed scenarios plus random play against a queue-based snake model.
module tb_snake_body;
  localparam int TB_MAX_LEN = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  snake_body_if bus();
  snake_body #(.MAX_LEN(TB_MAX_LEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Model: segment queues with the head at index 0.
  int qx[$];
  int qy[$];
  int m_head;
  bit m_grow;
  bit m_dead;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int opposite(input int h);
    case (h)
      0:       return 1;
      1:       return 0;
      2:       return 3;
      default: return 2;
    endcase
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_vld"},        bus.vld,        0);
    check({tag, "_vld_start"},  bus.vld_start,  0);
    check({tag, "_vld_t"},      bus.vld_t,      0);
    check({tag, "_pixel_done"}, bus.pixel_done, 0);
    check({tag, "_is_end"},     bus.is_end,     0);
    check({tag, "_x"},          bus.x_snake_cur, qx[0]);
    check({tag, "_y"},          bus.y_snake_cur, qy[0]);
    check({tag, "_length"},     bus.length,     qx.size());
    check({tag, "_dead"},       bus.dead,       m_dead);
  endtask

  task automatic log_move(input int d);
    $display("[TB] move dir=%0d len=%0d head=(%0d,%0d) dead=%0d", d, qx.size(), qx[0], qy[0], m_dead);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    qx.delete(); qy.delete();
    qx.push_back(0); qy.push_back(0);
    m_head = 0; m_grow = 0; m_dead = 0;
    check_idle("reset");
    $display("[TB] reset");
  endtask

  // One game step: optional eat before the tick, during MOVE, and on stream cycle es.
  task automatic do_move(input logic [1:0] d, input bit eat_idle, input bit eat_move, input int es);
    int nx, ny, n;
    bit off, g, hit;
    if (eat_idle) begin
      bus.is_eat = 1'b1;
      @(negedge clk);
      bus.is_eat = 1'b0;
      if (!m_dead) m_grow = 1;
    end
    bus.tick = 1'b1;
    bus.dir  = d;
    @(negedge clk);
    bus.tick = 1'b0;
    if (m_dead) begin
      check("dead_tick_vld", bus.vld, 0);
      @(negedge clk);
      check_idle("dead_hold");
      log_move(d);
      return;
    end
    check("move_vld", bus.vld, 1);
    check("move_pixel_done", bus.pixel_done, 0);
    bus.is_eat = eat_move;
    if (int'(d) != opposite(m_head)) m_head = d;
    nx = qx[0];
    ny = qy[0];
    case (m_head)
      0:       nx = nx + 1;
      1:       nx = nx - 1;
      2:       ny = ny - 1;
      default: ny = ny + 1;
    endcase
    off = (nx < 0) || (nx > 31) || (ny < 0) || (ny > 23);
`ifdef SNAKE_WRAP_EN
    nx  = (nx + 32) % 32;
    ny  = (ny + 24) % 24;
    off = 0;
`endif
    g = m_grow;
    m_grow = eat_move;
    @(negedge clk);
    bus.is_eat = 1'b0;
    if (off) begin
      m_dead = 1;
      check_idle("edge_dead");
      log_move(d);
      return;
    end
    qx.push_front(nx);
    qy.push_front(ny);
    if (!(g && qx.size() <= TB_MAX_LEN)) begin
      void'(qx.pop_back());
      void'(qy.pop_back());
    end
    n = qx.size();
    for (int k = 0; k < n; k++) begin
      check("stream_x",          bus.x_snake_cur, qx[k]);
      check("stream_y",          bus.y_snake_cur, qy[k]);
      check("stream_vld_start",  bus.vld_start,   k == 0);
      check("stream_vld_t",      bus.vld_t,       k != 0);
      check("stream_is_end",     bus.is_end,      k == n - 1);
      check("stream_pixel_done", bus.pixel_done,  1);
      check("stream_vld",        bus.vld,         0);
      check("stream_length",     bus.length,      n);
      bus.is_eat = (k == es);
      if (k == es) m_grow = 1;
      @(negedge clk);
    end
    bus.is_eat = 1'b0;
    hit = 0;
    for (int i = 1; i < n; i++)
      if (qx[i] == qx[0] && qy[i] == qy[0]) hit = 1;
    m_dead = hit;
    check_idle("post_stream");
    log_move(d);
  endtask

  initial begin
    bus.tick   = 1'b0;
    bus.dir    = 2'd0;
    bus.is_eat = 1'b0;
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // First step right, reversal ignored, then growth by one.
    do_move(2'd0, 0, 0, -1);
    do_move(2'd1, 0, 0, -1);
    check("reverse_ignored_x", bus.x_snake_cur, 2);
    do_reset();
    do_move(2'd0, 1, 0, -1);
    check("grow_length", bus.length, 2);
    do_move(2'd0, 0, 0, -1);
    do_move(2'd0, 0, 1, -1);
    do_move(2'd0, 0, 0, -1);
    check("late_eat_length", bus.length, 3);

    // Right-edge step.
    do_reset();
    for (int i = 0; i < 5; i++)  do_move(2'd3, 0, 0, -1);
    for (int i = 0; i < 31; i++) do_move(2'd0, 0, 0, -1);
    do_move(2'd0, 0, 0, -1);
    do_move(2'd0, 0, 0, -1);

    // Length 5 turning back into itself.
    do_reset();
    for (int i = 0; i < 4; i++) do_move(2'd0, 1, 0, -1);
    do_move(2'd3, 0, 0, -1);
    do_move(2'd1, 0, 0, -1);
    do_move(2'd2, 0, 0, -1);
    check("self_collision_dead", bus.dead, 1);
    do_move(2'd0, 1, 0, -1);

    // Reset landing on stream cycle 2 of a length-4 snake.
    do_reset();
    for (int i = 0; i < 3; i++) do_move(2'd0, 1, 0, -1);
    bus.tick = 1'b1;
    bus.dir  = 2'd0;
    @(negedge clk);
    bus.tick = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_stream_pixel_done", bus.pixel_done, 1);
    check("mid_stream_length", bus.length, 4);
    do_reset();
    do_move(2'd0, 0, 0, -1);

    // Growth up to the length ceiling.
    do_reset();
    do_move(2'd3, 0, 0, -1);
    for (int i = 0; i < TB_MAX_LEN + 2; i++) do_move(2'd0, 1, 0, -1);
    check("ceiling_length", bus.length, TB_MAX_LEN);

    // Random play.
    do_reset();
    for (int t = 0; t < 300; t++) begin
      logic [1:0] d;
      int es;
      d  = 2'($urandom_range(0, 3));
      es = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TB_MAX_LEN - 1)) : -1;
      if (m_dead) begin
        do_move(d, 0, 0, -1);
        do_reset();
      end else begin
        do_move(d, $urandom_range(0, 1) == 0, $urandom_range(0, 4) == 0, es);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/snake_body.md
SNAKE_BODY -- requirements
Module: snake_body

Interface
REQ-001 Parameter H_LOGIC_MAX, default 5'd31: rightmost logical column.
REQ-002 Parameter V_LOGIC_MAX, default 5'd23: bottom logical row.
REQ-003 Parameter MAX_LEN, default 201: segment storage depth and length ceiling.
REQ-004 clk  in  1: the single clock; every state change on its rising edge.
REQ-005 rst  in  1: synchronous, active-high reset.
REQ-006 tick  in  1: single-cycle move-step request.
REQ-007 dir  in  2: requested heading: 0 right, 1 left, 2 up, 3 down.
REQ-008 is_eat  in  1: apple-eaten pulse from the apple block.
REQ-009 x_snake_cur  out  5: column of the segment being streamed.
REQ-010 y_snake_cur  out  5: row of the segment being streamed.
REQ-011 length  out  10: current segment count.
REQ-012 vld  out  1: one-cycle pulse marking the move (frame) update.
REQ-013 vld_start  out  1: high while segment 0 (head) is streamed.
REQ-014 vld_t  out  1: high while segments 1..length-1 are streamed.
REQ-015 pixel_done  out  1: high on every stream cycle.
REQ-016 is_end  out  1: high on the cycle the last segment is streamed.
REQ-017 dead  out  1: sticky game-over flag.

Function
REQ-018 FSM states IDLE, MOVE, STREAM, DEAD; IDLE->MOVE on tick; MOVE->STREAM after exactly 1 cycle; STREAM->IDLE after length cycles, or ->DEAD if a collision was flagged; DEAD left only by rst.
REQ-019 tick in MOVE, STREAM or DEAD is ignored and not queued.
REQ-020 MOVE cycle: vld=1; segment k takes segment k-1's value for k=1..length-1; head takes the new position.
REQ-021 Heading register updates from dir at MOVE only; a dir exactly opposite the current heading is ignored.
REQ-022 Head step: x+1, x-1, y-1 or y+1 per heading; x arithmetic is 5-bit; y wraps V_LOGIC_MAX->0 and 0->V_LOGIC_MAX.
REQ-023 is_eat in any state except DEAD sets grow_pending; at the next MOVE, if length<MAX_LEN, the old tail is retained as new last segment, length increments, and grow_pending clears; at length==MAX_LEN grow_pending clears with no growth.
REQ-024 is_eat coincident with MOVE is applied at the following MOVE, not the current one.
REQ-025 STREAM cycle k (k=0..length-1): x_snake_cur/y_snake_cur = segment k, pixel_done=1, vld_start=(k==0), vld_t=(k!=0), is_end=(k==length-1).
REQ-026 length==1: the single STREAM cycle has vld_start=1, is_end=1, vld_t=0.
REQ-027 Outside STREAM: vld_start, vld_t, pixel_done, is_end are 0; x/y hold the head.
REQ-028 During STREAM, the head is compared against each streamed segment k>=1; any match sets a collision flag consumed at stream end.
REQ-029 DEAD: dead=1, all pulses 0, segment storage and length frozen.

Reset
REQ-030 rst has priority over all events, in any state including mid-STREAM: state IDLE, heading right, length=1, segment 0=(0,0), x_snake_cur=0, y_snake_cur=0, grow_pending=0, collision=0, all pulse outputs 0, dead=0.

Configuration
REQ-031 Macro SNAKE_WRAP_EN defined: edge-wrap per REQ-022 in both axes (x 31->0, 0->31).
REQ-032 SNAKE_WRAP_EN undefined: a step beyond column 0..H_LOGIC_MAX or row 0..V_LOGIC_MAX leaves storage unchanged and goes MOVE->DEAD directly, with no STREAM.

Verification
REQ-033 Reset, tick with dir=0 -> vld at cycle +1, one STREAM cycle with (1,0), vld_start=1, is_end=1.
REQ-034 is_eat once, then 3 ticks with dir=0 -> length 2 after first move; stream (2,0),(1,0) then (3,0),(2,0); vld_t=1 on second cycle only.
REQ-035 Heading right, dir=1 at tick -> head still advances right.
REQ-036 Head at (31,5), dir=0, tick -> SNAKE_WRAP_EN: head (0,5); without: dead=1 at cycle +2, no pixel_done.
REQ-037 Length 5, ticks with dir sequence down, left, up -> self-collision, dead=1 after stream end; later ticks ignored.
REQ-038 rst asserted on stream cycle 2 of length 4 -> next cycle IDLE, length=1, head (0,0), all pulses 0.
